// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the int-to-float converter and the
// FP adder datapath.
//   FP_W / EXP_W / MANT_W / EXP_BIAS : IEEE-754 single-precision field sizes
//   cvt_state_t                      : converter control states
//   rnd_req_t / rnd_rsp_t            : request/response of the RNE rounder
//   pack_fp()                        : assemble {sign, exp, mant}
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } cvt_state_t;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              sticky;
        logic [EXP_W-1:0]  exp;
    } rnd_req_t;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              inexact;
    } rnd_rsp_t;

    function automatic logic [FP_W-1:0] pack_fp(input logic              sign,
                                                input logic [EXP_W-1:0]  exp,
                                                input logic [MANT_W-1:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a 23-bit mantissa.
//   req : {mant, guard, sticky, exp}  mantissa with the first discarded bit
//                                      (guard) and OR of the rest (sticky)
//   rsp : {mant, exp, inexact}        rounded mantissa, exponent bumped on
//                                      mantissa carry-out, discarded-bits flag
// Callers guarantee the exponent cannot overflow on the carry.
module fp_round_rne
    import fp_pkg::*;
(
    input  rnd_req_t req,
    output rnd_rsp_t rsp
);

    logic              round_up;
    logic [MANT_W:0]   mant_inc;

    always_comb begin
        round_up    = req.guard & (req.sticky | req.mant[0]);
        mant_inc    = {1'b0, req.mant} + {{MANT_W{1'b0}}, round_up};
        // On carry-out the low bits are already zero: 1.111..1 + ulp = 10.000..0
        rsp.mant    = mant_inc[MANT_W-1:0];
        rsp.exp     = req.exp + {{(EXP_W-1){1'b0}}, mant_inc[MANT_W]};
        rsp.inexact = req.guard | req.sticky;
    end

endmodule

// File: rtl/int_to_float_pack.sv
// Sequential 32-bit integer (signed or unsigned) to IEEE-754 single converter.
// Normalises by iterative left shift (coarse NORM_STEP or single bit per
// cycle), then rounds to nearest even and packs.
//   clk, res               : clock, synchronous active-high reset
//   in_valid/in_ready      : request handshake (in_ready only in IDLE)
//   in_data, in_signed     : operand and its interpretation
//   out_valid/out_ready    : result handshake (out_valid held until taken)
//   out_data, out_inexact  : packed float and rounding-inexact flag
// All outputs are registered.
module int_to_float_pack
    import fp_pkg::*;
#(
    parameter int NORM_STEP = 8,
    parameter int EXP_INIT  = 158
) (
    input  logic            clk,
    input  logic            res,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_data,
    input  logic            in_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_data,
    output logic            out_inexact
);

    cvt_state_t      state, state_nxt;

    logic [FP_W-1:0] data_q, data_nxt;
    logic            signed_q, signed_nxt;
    logic            sign_q, sign_nxt;
    logic [FP_W-1:0] mag_q, mag_nxt;
    logic [EXP_W:0]  exp_q, exp_nxt;

    logic            in_ready_nxt;
    logic            out_valid_nxt;
    logic [FP_W-1:0] out_data_nxt;
    logic            out_inexact_nxt;

    logic            sign_load;
    logic [FP_W-1:0] mag_load;
    logic            coarse;
    logic [FP_W-1:0] mag_sh;
    logic [EXP_W:0]  exp_sh;

    rnd_req_t        rnd_req;
    rnd_rsp_t        rnd_rsp;

    // Magnitude of the captured operand; -0x80000000 wraps back to 0x80000000,
    // which is exactly the unsigned magnitude wanted.
    assign sign_load = signed_q & data_q[FP_W-1];
    assign mag_load  = sign_load ? ((~data_q) + 32'd1) : data_q;

    // Coarse shift only when the whole top window is zero, so the leading one
    // is never shifted out.
    assign coarse = (mag_q[FP_W-1 -: NORM_STEP] == '0);
    assign mag_sh = coarse ? (mag_q << NORM_STEP) : (mag_q << 1);
    assign exp_sh = coarse ? (exp_q - (EXP_W+1)'(NORM_STEP)) : (exp_q - 9'd1);

    assign rnd_req.mant   = mag_q[FP_W-2:FP_W-1-MANT_W];
    assign rnd_req.guard  = mag_q[FP_W-2-MANT_W];
    assign rnd_req.sticky = |mag_q[FP_W-3-MANT_W:0];
    // Largest reachable exponent is 159, so the low 8 bits carry it fully.
    assign rnd_req.exp    = exp_q[EXP_W-1:0];

    fp_round_rne u_round (
        .req (rnd_req),
        .rsp (rnd_rsp)
    );

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid) state_nxt = LOAD;
            LOAD:  state_nxt = (mag_load == '0) ? DONE : NORM;
            // Leave as soon as the leading one reaches bit 31, including on
            // the cycle that performs the final shift.
            NORM:  if (mag_q[FP_W-1] || mag_sh[FP_W-1]) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_nxt        = data_q;
        signed_nxt      = signed_q;
        sign_nxt        = sign_q;
        mag_nxt         = mag_q;
        exp_nxt         = exp_q;
        out_valid_nxt   = 1'b0;
        out_data_nxt    = out_data;
        out_inexact_nxt = out_inexact;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_nxt   = in_data;
                    signed_nxt = in_signed;
                end
            end
            LOAD: begin
                sign_nxt = sign_load;
                mag_nxt  = mag_load;
                exp_nxt  = (EXP_W+1)'(EXP_INIT);
                if (mag_load == '0) begin
                    out_data_nxt    = '0;
                    out_inexact_nxt = 1'b0;
                end
            end
            NORM: begin
                if (!mag_q[FP_W-1]) begin
                    mag_nxt = mag_sh;
                    exp_nxt = exp_sh;
                end
            end
            ROUND: begin
                out_data_nxt    = pack_fp(sign_q, rnd_rsp.exp, rnd_rsp.mant);
                out_inexact_nxt = rnd_rsp.inexact;
            end
            DONE: begin
                // Raised on the first DONE cycle, dropped after the handshake.
                out_valid_nxt = out_valid ? ~out_ready : 1'b1;
            end
            default: ;
        endcase
        in_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            data_q      <= '0;
            signed_q    <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else begin
            data_q      <= data_nxt;
            signed_q    <= signed_nxt;
            sign_q      <= sign_nxt;
            mag_q       <= mag_nxt;
            exp_q       <= exp_nxt;
            in_ready    <= in_ready_nxt;
            out_valid   <= out_valid_nxt;
            out_data    <= out_data_nxt;
            out_inexact <= out_inexact_nxt;
        end
    end

endmodule
